// File: rtl/rr_fsm_arbiter.sv
// N-requester grant arbiter: registered one-hot grant, fixed-priority or
// round-robin selection, and a hold limit that forces release under contention.
module rr_fsm_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mode,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               forced_release
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GNT  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                forced_q, forced_d;

  logic                grant_new;
  logic [ID_W-1:0]     win_id;
  logic [NUM_REQ-1:0]  others;

  // Scans candidates starting at ptr (round robin) or at 0 (fixed priority);
  // the modulo wrap is explicit so non-power-of-two NUM_REQ works.
  function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] cand,
                                           input logic               rr_mode,
                                           input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx_v;
    logic            found;
    int              idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_mode ? int'(ptr) + k : k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = ID_W'(idx);
      if (!found && cand[idx_v]) begin
        win   = idx_v;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    forced_d  = 1'b0;
    grant_new = 1'b0;
    win_id    = '0;
    others    = req & ~gnt_q;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_new = 1'b1;
          win_id    = pick(req, mode, rr_ptr_q);
        end
      end
      S_GNT: begin
        if (!req[id_q]) begin
          if (|req) begin
            grant_new = 1'b1;
            win_id    = pick(req, mode, rr_ptr_q);
          end else begin
            state_d = S_IDLE;
            gnt_d   = '0;
            id_d    = '0;
            hold_d  = '0;
          end
        end else if (hold_q == HOLD_LAST && |others) begin
          // Holder is excluded from the candidates, so the hand-off is immediate.
          grant_new = 1'b1;
          win_id    = pick(others, mode, rr_ptr_q);
          forced_d  = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grant_new) begin
      state_d  = S_GNT;
      gnt_d    = NUM_REQ'(1) << win_id;
      id_d     = win_id;
      hold_d   = '0;
      rr_ptr_d = (win_id == ID_LAST) ? '0 : win_id + ID_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      forced_q <= forced_d;
    end
  end

  assign gnt            = gnt_q;
  assign gnt_valid      = |gnt_q;
  assign gnt_id         = id_q;
  assign forced_release = forced_q;

endmodule

// File: tb/tb_rr_fsm_arbiter.sv
// Directed bench for rr_fsm_arbiter (NUM_REQ=4, MAX_HOLD=4): a vector table for
// single-cycle steps plus hand sequences for long holds and mode switching.
module tb_rr_fsm_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode  = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       forced_release;

  int tests_run = 0;
  int tests_failed = 0;

  rr_fsm_arbiter #(.NUM_REQ(4), .MAX_HOLD(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .mode           (mode),
    .req            (req),
    .gnt            (gnt),
    .gnt_valid      (gnt_valid),
    .gnt_id         (gnt_id),
    .forced_release (forced_release)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       md;
    logic [3:0] rq;
    logic [3:0] exp_gnt;
    logic [1:0] exp_id;
    logic       exp_fr;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got {gnt,valid,id,fr}=%b expected %b", name, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge sample them, settle 1 time unit after it.
  task automatic apply(input logic r, input logic m, input logic [3:0] rq);
    reset = r;
    mode  = m;
    req   = rq;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] g,
                            input logic [1:0] id, input logic fr);
    check(name, {gnt, gnt_valid, gnt_id, forced_release}, {g, |g, id, fr});
  endtask

  initial begin
    // rst, mode, req, expected gnt, expected id, expected forced_release
    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'b1110, 4'b0010, 2'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'b1100, 4'b0100, 2'd2, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'b1110, 4'b0010, 2'd1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'b1101, 4'b0100, 2'd2, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 4'b1011, 4'b1000, 2'd3, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 4'b0111, 4'b0001, 2'd0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 4'b0101, 4'b0001, 2'd0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 4'b0101, 4'b0001, 2'd0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 4'b0101, 4'b0001, 2'd0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 4'b0101, 4'b0100, 2'd2, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 4'b0101, 4'b0100, 2'd2, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};

    for (int i = 0; i < 23; i++) begin
      apply(vecs[i].rst, vecs[i].md, vecs[i].rq);
      expect_out($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_id, vecs[i].exp_fr);
    end

    // Lone requester 3 for 20 cycles: hold counter saturates, no forced release.
    for (int c = 0; c < 20; c++) begin
      apply(1'b0, 1'b1, 4'b1000);
      expect_out($sformatf("solo_c%0d", c), 4'b1000, 2'd3, 1'b0);
    end

    // Mode switch mid-grant has no effect until the next arbitration point.
    apply(1'b0, 1'b1, 4'b0000);
    expect_out("ms_idle", 4'b0000, 2'd0, 1'b0);
    apply(1'b0, 1'b1, 4'b1000);
    expect_out("ms_hold3", 4'b1000, 2'd3, 1'b0);
    apply(1'b0, 1'b0, 4'b1011);
    expect_out("ms_keep3", 4'b1000, 2'd3, 1'b0);
    apply(1'b0, 1'b0, 4'b0011);
    expect_out("ms_fixed0", 4'b0001, 2'd0, 1'b0);
    apply(1'b0, 1'b0, 4'b0000);
    expect_out("ms_idle2", 4'b0000, 2'd0, 1'b0);
    // Pointer now 1: round robin must skip requester 0 and pick 3.
    apply(1'b0, 1'b1, 4'b1001);
    expect_out("ms_rr_ptr1", 4'b1000, 2'd3, 1'b0);
    apply(1'b0, 1'b1, 4'b0000);
    expect_out("ms_idle3", 4'b0000, 2'd0, 1'b0);
    // Pointer wrapped to 0 after granting 3: requester 0 comes first.
    apply(1'b0, 1'b1, 4'b1001);
    expect_out("ms_rr_ptr0", 4'b0001, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
